// File: rtl/vga_color_ctrl.sv
// Switch synchroniser, per-bit debouncer and vsync-aligned colour commit.
// Optional VGA_BLINK_EN blanks rgb_sel on alternate BLINK_FRAMES-frame periods.
module vga_color_ctrl #(
    parameter int unsigned DB_CYCLES    = 1000000,
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw_raw,
    input  logic       vsync,
    output logic [2:0] rgb_sel,
    output logic [2:0] sw_stable,
    output logic       color_changed
);

    typedef enum logic {
        DB_IDLE,
        DB_COUNT
    } db_state_e;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic [2:0]       s1_q;
    logic [2:0]       s2_q;
    db_state_e        db_state_q [3];
    db_state_e        db_state_d [3];
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       stable_q;
    logic [2:0]       stable_d;
    logic             vsync_q;
    logic             vs_rise;
    logic [2:0]       color_q;
    logic [2:0]       color_d;
    logic             changed_q;
    logic             changed_d;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            db_state_d[i] = db_state_q[i];
            cnt_d[i]      = cnt_q[i];
            stable_d[i]   = stable_q[i];
            unique case (db_state_q[i])
                DB_IDLE: begin
                    if (s2_q[i] != stable_q[i]) begin
                        db_state_d[i] = DB_COUNT;
                        cnt_d[i]      = CNT_W'(1);
                    end
                end
                DB_COUNT: begin
                    if (s2_q[i] == stable_q[i]) begin
                        db_state_d[i] = DB_IDLE;
                        cnt_d[i]      = '0;
                    end else if (cnt_q[i] == DB_LAST) begin
                        stable_d[i]   = s2_q[i];
                        db_state_d[i] = DB_IDLE;
                        cnt_d[i]      = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign vs_rise = vsync & ~vsync_q;

    // Commit from the registered stable value, so a same-edge acceptance waits a frame.
    always_comb begin
        color_d   = color_q;
        changed_d = 1'b0;
        if (vs_rise && (stable_q != color_q)) begin
            color_d   = stable_q;
            changed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            vsync_q   <= 1'b0;
            color_q   <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                db_state_q[i] <= DB_IDLE;
                cnt_q[i]      <= '0;
            end
        end else begin
            s1_q      <= sw_raw;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            vsync_q   <= vsync;
            color_q   <= color_d;
            changed_q <= changed_d;
            for (int i = 0; i < 3; i++) begin
                db_state_q[i] <= db_state_d[i];
                cnt_q[i]      <= cnt_d[i];
            end
        end
    end

    assign sw_stable     = stable_q;
    assign color_changed = changed_q;

`ifdef VGA_BLINK_EN
    localparam int unsigned FR_W =
        (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

    logic [FR_W-1:0] frame_q;
    logic [FR_W-1:0] frame_d;
    logic            blink_q;
    logic            blink_d;

    always_comb begin
        frame_d = frame_q;
        blink_d = blink_q;
        if (vs_rise) begin
            if (frame_q == FR_LAST) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + FR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= '0;
            blink_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            blink_q <= blink_d;
        end
    end

    assign rgb_sel = blink_q ? 3'b000 : color_q;
`else
    assign rgb_sel = color_q;
`endif

endmodule

// File: tb/tb_vga_color_ctrl.sv
// Scoreboard bench for vga_color_ctrl with DB_CYCLES=4, BLINK_FRAMES=2.
// Build with +define+VGA_BLINK_EN to also exercise the blink option.
module tb_vga_color_ctrl;

    localparam int DB = 4;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] sw_raw = 3'b000;
    logic       vsync = 1'b0;
    logic [2:0] rgb_sel;
    logic [2:0] sw_stable;
    logic       color_changed;

    vga_color_ctrl #(
        .DB_CYCLES   (DB),
        .CNT_W       (3),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_raw       (sw_raw),
        .vsync        (vsync),
        .rgb_sel      (rgb_sel),
        .sw_stable    (sw_stable),
        .color_changed(color_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] val;
        int         cyc;
    } exp_t;

    exp_t       q_stable[$];
    exp_t       q_commit[$];
    exp_t       me;
    int         cyc = 0;
    logic       rst_seen = 1'b1;
    logic [2:0] prev_stable = 3'b000;
    int         n_tests = 0;
    int         n_fail = 0;
    int         nrise = 0;
    logic [2:0] t6_exp [4];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    function automatic logic [2:0] shown(input logic [2:0] c);
`ifdef VGA_BLINK_EN
        return (((nrise / BF) % 2) == 1) ? 3'b000 : c;
`else
        return c;
`endif
    endfunction

    task automatic check(input string name, input logic [2:0] act,
                         input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input bit accept);
        exp_t e;
        @(posedge clk);
        #1;
        sw_raw = v;
        if (accept) begin
            e.val = v;
            e.cyc = cyc + DB + 2;
            q_stable.push_back(e);
        end
    endtask

    task automatic frame(input int hold, input bit commit,
                         input logic [2:0] v);
        exp_t e;
        @(posedge clk);
        #1;
        vsync = 1'b1;
        nrise++;
        if (commit) begin
            e.val = shown(v);
            e.cyc = cyc + 1;
            q_commit.push_back(e);
        end
        repeat (hold) @(posedge clk);
        #1;
        vsync = 1'b0;
    endtask

    // Monitor: each observed output event must match the head of its queue.
    always @(negedge clk) begin
        if (!rst_seen) begin
            if (sw_stable !== prev_stable) begin
                n_tests++;
                if (q_stable.size() == 0) begin
                    n_fail++;
                    $display("FAIL stable_unexpected: got %b at cyc %0d, none expected",
                             sw_stable, cyc);
                end else begin
                    me = q_stable.pop_front();
                    if (sw_stable !== me.val || cyc != me.cyc) begin
                        n_fail++;
                        $display("FAIL stable_event: got %b at cyc %0d want %b at cyc %0d",
                                 sw_stable, cyc, me.val, me.cyc);
                    end
                end
            end
            if (color_changed === 1'b1) begin
                n_tests++;
                if (q_commit.size() == 0) begin
                    n_fail++;
                    $display("FAIL commit_unexpected: rgb %b at cyc %0d, no pulse expected",
                             rgb_sel, cyc);
                end else begin
                    me = q_commit.pop_front();
                    if (rgb_sel !== me.val || cyc != me.cyc) begin
                        n_fail++;
                        $display("FAIL commit_event: got %b at cyc %0d want %b at cyc %0d",
                                 rgb_sel, cyc, me.val, me.cyc);
                    end
                end
            end
        end
        prev_stable = sw_stable;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        t6_exp[0] = 3'b000;
        t6_exp[1] = 3'b110;
        t6_exp[2] = 3'b110;
        t6_exp[3] = 3'b000;

        cycles(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_rgb", rgb_sel, 3'b000);
        check("rst_stable", sw_stable, 3'b000);
        check("rst_chg", {2'b00, color_changed}, 3'b000);

        // 1: plain accept, then commit at the next frame
        drive(3'b101, 1);
        cycles(8);
        @(negedge clk);
        check("t1_hold", rgb_sel, shown(3'b000));
        frame(3, 1, 3'b101);
        cycles(4);
        @(negedge clk);
        check("t1_rgb", rgb_sel, shown(3'b101));

        // 2: bit0 bounces in 2-cycle runs, then rests low
        drive(3'b100, 0);
        cycles(1);
        drive(3'b101, 0);
        cycles(1);
        drive(3'b100, 0);
        cycles(1);
        drive(3'b101, 0);
        cycles(1);
        drive(3'b100, 1);
        cycles(8);
        frame(3, 1, 3'b100);
        cycles(4);

        // 3: three accepted values in one frame, only the last is shown
        drive(3'b001, 1);
        cycles(7);
        @(negedge clk);
        check("t3_mid", rgb_sel, shown(3'b100));
        drive(3'b011, 1);
        cycles(7);
        drive(3'b111, 1);
        cycles(7);
        frame(3, 1, 3'b111);
        cycles(4);
        @(negedge clk);
        check("t3_rgb", rgb_sel, shown(3'b111));

        // 4: long vsync, nothing new to commit
        frame(20, 0, 3'b000);
        cycles(4);
        @(negedge clk);
        check("t4_rgb", rgb_sel, shown(3'b111));

        // 5: reset in the middle of a debounce count
        drive(3'b010, 0);
        cycles(4);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        nrise = 0;
        me.val = 3'b010;
        me.cyc = cyc + DB + 2;
        q_stable.push_back(me);
        @(negedge clk);
        check("t5_rgb", rgb_sel, 3'b000);
        check("t5_stable", sw_stable, 3'b000);
        check("t5_chg", {2'b00, color_changed}, 3'b000);
        cycles(8);
        frame(3, 1, 3'b010);
        cycles(4);
        @(negedge clk);
        check("t5_rgb_after", rgb_sel, shown(3'b010));

`ifdef VGA_BLINK_EN
        // 6: blink alternates every two frames, no pulses
        drive(3'b110, 1);
        cycles(8);
        frame(3, 1, 3'b110);
        cycles(4);
        @(negedge clk);
        check("t6_commit", rgb_sel, 3'b000);
        for (int i = 0; i < 4; i++) begin
            frame(3, 0, 3'b000);
            cycles(4);
            @(negedge clk);
            check("t6_blink", rgb_sel, t6_exp[i]);
        end
`endif

        cycles(10);
        n_tests++;
        if (q_stable.size() != 0) begin
            n_fail++;
            $display("FAIL stable_left: %0d pending, want 0", q_stable.size());
        end
        n_tests++;
        if (q_commit.size() != 0) begin
            n_fail++;
            $display("FAIL commit_left: %0d pending, want 0", q_commit.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
